// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings and stage-entry widths for the forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int REG_ZERO = 0;

  // Stage entries: EX {valid, rs, rt, rd, reg_write, mem_read}; MEM/WB {valid, rd, reg_write}
  localparam int REG_W_DEF   = 5;
  localparam int EX_CTRL_W   = 3;
  localparam int WB_CTRL_W   = 2;
  localparam int EX_ENTRY_W  = EX_CTRL_W + 3 * REG_W_DEF;
  localparam int MEM_ENTRY_W = WB_CTRL_W + REG_W_DEF;
  localparam int WB_ENTRY_W  = WB_CTRL_W + REG_W_DEF;

endpackage

// File: rtl/fwd_hazard_ctrl_sel_unit.sv
// Priority compare for one ALU operand: MEM result beats WB result beats register file.
module fwd_sel_unit
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_vld,
  input  logic [REG_W-1:0] src,
  input  logic             mem_vld,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_vld,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_vld & mem_reg_write & (mem_rd != REG_W'(REG_ZERO)) & (mem_rd == src);
  assign wb_hit  = wb_vld & wb_reg_write & (wb_rd != REG_W'(REG_ZERO)) & (wb_rd == src);

  always_comb begin
    sel = FWD_REG;
    if (ex_vld) begin
      if (mem_hit)     sel = FWD_MEM;
      else if (wb_hit) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller with an EX/MEM/WB shadow pipeline.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             vld_p0, rw_p0, mr_p0;
  logic [REG_W-1:0] rs_p0, rt_p0, rd_p0;
  logic             vld_p1, rw_p1;
  logic [REG_W-1:0] rd_p1;
  logic             vld_p2, rw_p2;
  logic [REG_W-1:0] rd_p2;
  logic             issue;

  assign stall = id_valid & ~flush & vld_p0 & mr_p0 & rw_p0 &
                 (rd_p0 != REG_W'(REG_ZERO)) & ((rd_p0 == id_rs) | (rd_p0 == id_rt));

  // A stalled, flushed or empty ID slot enters EX as a bubble
  assign issue = id_valid & ~stall & ~flush;

  // p0 = EX, p1 = MEM, p2 = WB: control bits reset, register indices free-run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      rw_p0       <= 1'b0;
      mr_p0       <= 1'b0;
      vld_p1      <= 1'b0;
      rw_p1       <= 1'b0;
      vld_p2      <= 1'b0;
      rw_p2       <= 1'b0;
      stall_count <= '0;
    end else begin
      vld_p0 <= issue;
      rw_p0  <= issue & id_reg_write;
      mr_p0  <= issue & id_mem_read;
      vld_p1 <= vld_p0;
      rw_p1  <= rw_p0;
      vld_p2 <= vld_p1;
      rw_p2  <= rw_p1;
      if (stall) stall_count <= sat_inc(stall_count);
    end
  end

  always_ff @(posedge clk) begin
    rs_p0 <= id_rs;
    rt_p0 <= id_rt;
    rd_p0 <= id_rd;
    rd_p1 <= rd_p0;
    rd_p2 <= rd_p1;
  end

  fwd_sel_unit #(.REG_W(REG_W)) u_sel_a (
    .ex_vld        (vld_p0),
    .src           (rs_p0),
    .mem_vld       (vld_p1),
    .mem_reg_write (rw_p1),
    .mem_rd        (rd_p1),
    .wb_vld        (vld_p2),
    .wb_reg_write  (rw_p2),
    .wb_rd         (rd_p2),
    .sel           (fwd_a_sel)
  );

  fwd_sel_unit #(.REG_W(REG_W)) u_sel_b (
    .ex_vld        (vld_p0),
    .src           (rt_p0),
    .mem_vld       (vld_p1),
    .mem_reg_write (rw_p1),
    .mem_rd        (rd_p1),
    .wb_vld        (vld_p2),
    .wb_reg_write  (rw_p2),
    .wb_rd         (rd_p2),
    .sel           (fwd_b_sel)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, load-use stall, flush, reset, saturation.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall;
  logic [15:0] stall_count;
  logic [1:0]  s_a_sel, s_b_sel;
  logic        s_stall;
  logic [7:0]  s_count;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(s_a_sel), .fwd_b_sel(s_b_sel), .stall(s_stall), .stall_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // New ID contents just after a rising edge; returns at the following falling edge.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl;
    @(negedge clk);
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    #2;
    chk("reset_a", 32'(fwd_a_sel), 32'd0);
    chk("reset_b", 32'(fwd_b_sel), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back: add r3,r1,r2 ; sub r5,r3,r4
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
    drive(1, 5'd3, 5'd4, 5'd5, 1, 0, 0);
    chk("b2b_add_ex_a", 32'(fwd_a_sel), 32'd0);
    chk("b2b_stall", 32'(stall), 32'd0);
    nop();
    chk("b2b_sub_a", 32'(fwd_a_sel), 32'd2);
    chk("b2b_sub_b", 32'(fwd_b_sel), 32'd0);
    nop(); nop();

    // double writer of r5: MEM wins over WB
    drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    drive(1, 5'd5, 5'd9, 5'd6, 1, 0, 0);
    nop();
    chk("dbl_mem_prio_a", 32'(fwd_a_sel), 32'd2);
    chk("dbl_b", 32'(fwd_b_sel), 32'd0);

    // only the 2-ahead writer of r5, used as operand B
    drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    drive(1, 5'd1, 5'd2, 5'd10, 1, 0, 0);
    drive(1, 5'd9, 5'd5, 5'd11, 1, 0, 0);
    nop();
    chk("dist2_a", 32'(fwd_a_sel), 32'd0);
    chk("dist2_wb_b", 32'(fwd_b_sel), 32'd1);
    nop(); nop();

    // load-use: lw r7,0(r1) ; add r8,r7,r1
    drive(1, 5'd1, 5'd0, 5'd7, 1, 1, 0);
    chk("lu_lw_nostall", 32'(stall), 32'd0);
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 0);
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_count_before", 32'(stall_count), 32'd0);
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 0);
    chk("lu_stall_released", 32'(stall), 32'd0);
    chk("lu_bubble_a", 32'(fwd_a_sel), 32'd0);
    chk("lu_bubble_b", 32'(fwd_b_sel), 32'd0);
    chk("lu_count_after", 32'(stall_count), 32'd1);
    nop();
    chk("lu_add_wb_a", 32'(fwd_a_sel), 32'd1);
    chk("lu_add_b", 32'(fwd_b_sel), 32'd0);
    nop(); nop();

    // register 0 never stalls or forwards
    drive(1, 5'd1, 5'd0, 5'd0, 1, 1, 0);
    drive(1, 5'd0, 5'd0, 5'd9, 1, 0, 0);
    chk("r0_nostall", 32'(stall), 32'd0);
    nop();
    chk("r0_a", 32'(fwd_a_sel), 32'd0);
    chk("r0_b", 32'(fwd_b_sel), 32'd0);
    chk("r0_count", 32'(stall_count), 32'd1);
    nop(); nop();

    // flush beats stall
    drive(1, 5'd1, 5'd0, 5'd7, 1, 1, 0);
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 1);
    chk("flush_stall", 32'(stall), 32'd0);
    nop();
    chk("flush_bubble_a", 32'(fwd_a_sel), 32'd0);
    chk("flush_count", 32'(stall_count), 32'd1);
    nop(); nop();

    // load-use via operand B: lw r12 ; add r13,r1,r12
    drive(1, 5'd1, 5'd0, 5'd12, 1, 1, 0);
    drive(1, 5'd1, 5'd12, 5'd13, 1, 0, 0);
    chk("rt_stall", 32'(stall), 32'd1);
    drive(1, 5'd1, 5'd12, 5'd13, 1, 0, 0);
    chk("rt_stall_released", 32'(stall), 32'd0);
    chk("rt_count", 32'(stall_count), 32'd2);
    nop();
    chk("rt_wb_b", 32'(fwd_b_sel), 32'd1);
    chk("rt_a", 32'(fwd_a_sel), 32'd0);
    nop(); nop();

    // asynchronous reset mid-stream with a stall pending
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
    drive(1, 5'd3, 5'd0, 5'd7, 1, 1, 0);
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 0);
    chk("mid_a_before", 32'(fwd_a_sel), 32'd2);
    chk("mid_stall_before", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", 32'(fwd_a_sel), 32'd0);
    chk("mid_rst_b", 32'(fwd_b_sel), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 5'd7, 5'd1, 5'd8, 1, 0, 0);
    chk("post_rst_nostall", 32'(stall), 32'd0);
    nop();
    chk("post_rst_a", 32'(fwd_a_sel), 32'd0);
    nop(); nop();

    // saturation of the 8-bit counter
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("sat_rst_count", 32'(s_count), 32'd0);
    for (int i = 0; i < 510; i++) drive(1, 5'd7, 5'd0, 5'd7, 1, 1, 0);
    drive(1, 5'd7, 5'd0, 5'd7, 1, 1, 0);
    chk("sat_reach_255", 32'(s_count), 32'd255);
    chk("wide_count_255", 32'(stall_count), 32'd255);
    chk("sat_gap_nostall", 32'(s_stall), 32'd0);
    drive(1, 5'd7, 5'd0, 5'd7, 1, 1, 0);
    chk("sat_stall_again", 32'(s_stall), 32'd1);
    drive(1, 5'd7, 5'd0, 5'd7, 1, 1, 0);
    chk("sat_hold_255", 32'(s_count), 32'd255);
    chk("wide_count_256", 32'(stall_count), 32'd256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks destination-register information through EX, MEM and WB in its own shadow pipeline. From that state it drives the 2-bit select inputs of the two 3:1 ALU-operand forwarding muxes. It also raises a one-cycle stall on load-use hazards and bubbles the EX stage on flush.

## Interface
- `REG_W`, 5: register-index width.
- `CNT_W`, 16: stall-counter width.

- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `id_valid`, in, 1: the ID stage holds a real instruction.
- `id_rs`, in, REG_W: source register A of the ID instruction.
- `id_rt`, in, REG_W: source register B of the ID instruction.
- `id_rd`, in, REG_W: destination register of the ID instruction.
- `id_reg_write`, in, 1: the ID instruction writes `id_rd`.
- `id_mem_read`, in, 1: the ID instruction is a load.
- `flush`, in, 1: the ID instruction is squashed (taken branch/jump).
- `fwd_a_sel`, out, 2: select for the EX operand-A mux.
- `fwd_b_sel`, out, 2: select for the EX operand-B mux.
- `stall`, out, 1: hold PC and IF/ID this cycle; a bubble enters EX.
- `stall_count`, out, CNT_W: saturating count of stall cycles.

## Operation
- Select encoding, matching the mux input order:
  - 2'b00: register-file value from ID/EX.
  - 2'b01: MEM/WB writeback value.
  - 2'b10: EX/MEM ALU result.
  - 2'b11 is never driven (the mux outputs 0 for it).
- Shadow stages:
  - EX holds {valid, rs, rt, rd, reg_write, mem_read}.
  - MEM holds {valid, rd, reg_write}.
  - WB holds {valid, rd, reg_write}.
- Each edge: WB←MEM, MEM←EX, EX←ID entry.
- The EX entry becomes a bubble (valid=0, reg_write=0, mem_read=0) when `stall`, `flush` or `!id_valid`.
- Forward condition for operand A (B is identical with rt):
  - MEM match: MEM.valid & MEM.reg_write & MEM.rd≠0 & MEM.rd==EX.rs → 2'b10.
  - Otherwise WB match (same test on WB) → 2'b01.
  - Otherwise 2'b00.
  - MEM has priority over WB. EX invalid → 2'b00.
- Register 0 is never forwarded and never causes a stall.
- Load-use stall: `stall`=1 when all of the following hold:
  - id_valid, !flush;
  - EX.valid & EX.mem_read & EX.reg_write & EX.rd≠0;
  - EX.rd==id_rs or EX.rd==id_rt.
- A stall lasts exactly one cycle. Next cycle the load is in MEM, EX is a bubble, the stall condition is false, and the dependent instruction is later served by WB forwarding (2'b01).
- Flush and stall together: flush wins, `stall`=0, and EX loads a bubble.
- WB→ID same-cycle hazards are resolved by the register file (write-before-read). This block does not forward into ID.
- `stall_count` increments on every cycle with `stall`=1 and saturates at all-ones.

## Timing
- `fwd_a_sel` and `fwd_b_sel` are combinational from registered shadow state only. They are valid early in the cycle, with no input-to-output path.
- `stall` is combinational from `id_*`, `flush` and the registered EX state. It must settle in the same cycle so that PC and IF/ID enables see it.
- Shadow state and `stall_count` update on the rising `clk` edge.
- Reset (`rst_n`=0, asynchronous):
  - all shadow stages invalid;
  - `fwd_a_sel` = `fwd_b_sel` = 2'b00;
  - `stall`=0 (when `id_valid` is low or EX is invalid);
  - `stall_count`=0.
- Reset mid-stream discards all in-flight tracking. The first post-reset instruction sees 2'b00 selects for 3 cycles, until the shadow pipeline refills.
- Instruction latency through the tracker: it enters EX one edge after being in ID, and reaches WB three edges after ID.

## Structure
- Shared package/header:
  - `FWD_REG`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - `REG_ZERO`=0;
  - stage-entry field widths.
- One sub-module, `fwd_sel_unit`: pure-combinational priority compare for one operand (src reg, MEM/WB entries → 2-bit select). It is instantiated twice (A, B).
- Shadow registers, stall logic and counter live in the top.

## Test plan
- Back-to-back ALU dependency: add r3 in ID, then sub using r3/r4 → in sub's EX cycle, fwd_a_sel=2'b10 and fwd_b_sel=2'b00.
- Distance-2 dependency with double match: r5 written by the instructions 1 and 2 ahead → fwd sel=2'b10 (MEM priority). With only the 2-ahead writer → 2'b01.
- Load-use: lw r7, then add r8,r7,r1 → stall=1 for exactly one cycle. Next EX is a bubble (selects 00). The add's EX cycle has fwd_a_sel=2'b01. stall_count goes 0→1.
- Register 0: lw r0 then add using r0 → no stall; selects stay 00.
- Flush with stall: load in EX, dependent in ID, flush=1 → stall=0, EX bubble, stall_count unchanged.
- Async reset mid-stream: assert rst_n=0 between edges → selects 00, stall 0 and count 0 immediately. Saturation check: preload an 8-bit CNT_W build to 255 and stall again → stays 255.
